// File: rtl/scale_engine.sv
// scale_engine: framebuffer zoom engine.
// Handles single-pixel RD/WR commands and full-frame zoom-in (pixel
// replication) or zoom-out (nearest-neighbour decimation) passes by x2 or
// x4 between a source and a destination buffer in a dual-port pixel RAM.
module scale_engine #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17,
  parameter int PIX_W  = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        operation,
  input  logic [1:0]        scale_shift,
  input  logic              clear_en,
  input  logic [PIX_W-1:0]  fill_color,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [PIX_W-1:0]  data_in,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic [PIX_W-1:0]  data_out,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        state_dbg
);

  localparam int XW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int WCW = $clog2(RD_LAT + 1);

  localparam logic [2:0] OP_RD   = 3'b001;
  localparam logic [2:0] OP_WR   = 3'b010;
  localparam logic [2:0] OP_ZIN  = 3'b011;
  localparam logic [2:0] OP_ZOUT = 3'b100;

  // Last x/y index of the full frame and of the x2 / x4 windows
  localparam logic [XW-1:0] XL_FULL = XW'(IMG_W - 1);
  localparam logic [XW-1:0] XL_HALF = XW'((IMG_W >> 1) - 1);
  localparam logic [XW-1:0] XL_QTR  = XW'((IMG_W >> 2) - 1);
  localparam logic [YW-1:0] YL_FULL = YW'(IMG_H - 1);
  localparam logic [YW-1:0] YL_HALF = YW'((IMG_H >> 1) - 1);
  localparam logic [YW-1:0] YL_QTR  = YW'((IMG_H >> 2) - 1);

  // Origin of the centred 1/F window for F = 2 and F = 4
  localparam logic [XW-1:0] OFFX1 = XW'((IMG_W - (IMG_W >> 1)) / 2);
  localparam logic [XW-1:0] OFFX2 = XW'((IMG_W - (IMG_W >> 2)) / 2);
  localparam logic [YW-1:0] OFFY1 = YW'((IMG_H - (IMG_H >> 1)) / 2);
  localparam logic [YW-1:0] OFFY2 = YW'((IMG_H - (IMG_H >> 2)) / 2);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_WRITE    = 3'd4,
    S_ADVANCE  = 3'd5,
    S_FINISH   = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        op_q, op_d;
  logic [1:0]        scale_q, scale_d;
  logic [PIX_W-1:0]  fill_q, fill_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  data_q, data_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [WCW-1:0]    wait_q, wait_d;
  logic              cache_vld_q, cache_vld_d;
  logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
  logic [PIX_W-1:0]  cache_pix_q, cache_pix_d;
  logic [PIX_W-1:0]  dout_q, dout_d;
  logic              error_q, error_d;

  logic              cmd_legal;
  logic              is_zoom_cmd;
  logic [XW-1:0]     x_last, off_x, src_x, dst_x;
  logic [YW-1:0]     y_last, off_y, src_y, dst_y;
  logic              last_x, last_y, last_pix;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic              cache_hit;
  logic              wait_done;

  // Linear RAM address of pixel (px, py) in a buffer; wraps at ADDR_W bits
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [XW-1:0]     px,
                                                 input logic [YW-1:0]     py);
    pix_addr = base + (ADDR_W'(py) * ADDR_W'(IMG_W)) + ADDR_W'(px);
  endfunction

  // Command legality, raster limits and source/destination addressing
  always_comb begin
    is_zoom_cmd = (operation == OP_ZIN) || (operation == OP_ZOUT);
    cmd_legal   = ((operation == OP_RD) || (operation == OP_WR) || is_zoom_cmd) &&
                  (!is_zoom_cmd || (scale_shift == 2'd1) || (scale_shift == 2'd2));

    off_x = (scale_q == 2'd2) ? OFFX2 : OFFX1;
    off_y = (scale_q == 2'd2) ? OFFY2 : OFFY1;

    // Zoom-out decimation walks only the shrunken window; clear walks all
    if ((op_q == OP_ZOUT) && (state_q != S_CLEAR)) begin
      x_last = (scale_q == 2'd2) ? XL_QTR : XL_HALF;
      y_last = (scale_q == 2'd2) ? YL_QTR : YL_HALF;
    end else begin
      x_last = XL_FULL;
      y_last = YL_FULL;
    end
    last_x   = (x_q == x_last);
    last_y   = (y_q == y_last);
    last_pix = last_x && last_y;

    if (op_q == OP_ZOUT) begin
      src_x = x_q << scale_q;
      src_y = y_q << scale_q;
    end else begin
      src_x = (x_q >> scale_q) + off_x;
      src_y = (y_q >> scale_q) + off_y;
    end

    if ((op_q == OP_ZOUT) && (state_q != S_CLEAR)) begin
      dst_x = x_q + off_x;
      dst_y = y_q + off_y;
    end else begin
      dst_x = x_q;
      dst_y = y_q;
    end

    src_addr  = pix_addr(src_q, src_x, src_y);
    dst_addr  = pix_addr(dst_q, dst_x, dst_y);
    cache_hit = cache_vld_q && (cache_addr_q == src_addr);
    wait_done = (wait_q == WCW'(RD_LAT));
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic; abort overrides every non-idle transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && cmd_legal) begin
          unique case (operation)
            OP_WR:   state_d = S_WRITE;
            OP_ZOUT: state_d = clear_en ? S_CLEAR : S_RD_ISSUE;
            default: state_d = S_RD_ISSUE;
          endcase
        end
      end
      S_CLEAR:    if (last_pix) state_d = S_RD_ISSUE;
      S_RD_ISSUE: state_d = ((op_q == OP_ZIN) && cache_hit) ? S_WRITE : S_RD_WAIT;
      S_RD_WAIT:  if (wait_done) state_d = (op_q == OP_RD) ? S_FINISH : S_WRITE;
      S_WRITE:    state_d = (op_q == OP_WR) ? S_FINISH : S_ADVANCE;
      S_ADVANCE:  state_d = last_pix ? S_FINISH : S_RD_ISSUE;
      S_FINISH:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // FSM outputs: RAM strobes with addresses held at zero when idle
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    done    = 1'b0;
    busy    = (state_q != S_IDLE) && (state_q != S_FINISH);
    unique case (state_q)
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = dst_addr;
        wr_data = fill_q;
      end
      S_RD_ISSUE: begin
        if (op_q == OP_RD) begin
          rd_en   = 1'b1;
          rd_addr = addr_q;
        end else if (!((op_q == OP_ZIN) && cache_hit)) begin
          rd_en   = 1'b1;
          rd_addr = src_addr;
        end
      end
      S_WRITE: begin
        wr_en = 1'b1;
        if (op_q == OP_WR) begin
          wr_addr = addr_q;
          wr_data = data_q;
        end else begin
          wr_addr = dst_addr;
          wr_data = cache_pix_q;
        end
      end
      S_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: command latch, raster counters, read wait, cache
  always_comb begin
    op_d         = op_q;
    scale_d      = scale_q;
    fill_d       = fill_q;
    src_d        = src_q;
    dst_d        = dst_q;
    addr_d       = addr_q;
    data_d       = data_q;
    x_d          = x_q;
    y_d          = y_q;
    wait_d       = wait_q;
    cache_vld_d  = cache_vld_q;
    cache_addr_d = cache_addr_q;
    cache_pix_d  = cache_pix_q;
    dout_d       = dout_q;
    error_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cmd_legal) begin
            op_d        = operation;
            scale_d     = scale_shift;
            fill_d      = fill_color;
            src_d       = src_base;
            dst_d       = dst_base;
            addr_d      = addr_in;
            data_d      = data_in;
            x_d         = '0;
            y_d         = '0;
            cache_vld_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_CLEAR, S_ADVANCE: begin
        if (last_pix) begin
          x_d = '0;
          y_d = '0;
        end else if (last_x) begin
          x_d = '0;
          y_d = y_q + YW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      S_RD_ISSUE: wait_d = WCW'(1);
      S_RD_WAIT: begin
        if (wait_done) begin
          if (op_q == OP_RD) begin
            dout_d = rd_data;
          end else begin
            cache_pix_d  = rd_data;
            cache_addr_d = src_addr;
            cache_vld_d  = 1'b1;
          end
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      default: ;
    endcase

    // Aborting drops any read in flight and forgets the cached pixel
    if (abort && (state_q != S_IDLE)) begin
      cache_vld_d = 1'b0;
      dout_d      = dout_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q         <= '0;
      scale_q      <= '0;
      fill_q       <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      wait_q       <= '0;
      cache_vld_q  <= 1'b0;
      cache_addr_q <= '0;
      cache_pix_q  <= '0;
      dout_q       <= '0;
      error_q      <= 1'b0;
    end else begin
      op_q         <= op_d;
      scale_q      <= scale_d;
      fill_q       <= fill_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      x_q          <= x_d;
      y_q          <= y_d;
      wait_q       <= wait_d;
      cache_vld_q  <= cache_vld_d;
      cache_addr_q <= cache_addr_d;
      cache_pix_q  <= cache_pix_d;
      dout_q       <= dout_d;
      error_q      <= error_d;
    end
  end

  assign data_out  = dout_q;
  assign error     = error_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_scale_engine.sv
// tb_scale_engine: directed bench for scale_engine on an 8x4 frame with a
// two-cycle-latency RAM model owned by the bench.
module tb_scale_engine;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 4;
  localparam int ADDR_W = 8;
  localparam int PIX_W  = 8;
  localparam int RD_LAT = 2;

  localparam logic [2:0] OP_RD   = 3'b001;
  localparam logic [2:0] OP_WR   = 3'b010;
  localparam logic [2:0] OP_ZIN  = 3'b011;
  localparam logic [2:0] OP_ZOUT = 3'b100;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              start;
  logic [2:0]        operation;
  logic [1:0]        scale_shift;
  logic              clear_en;
  logic [PIX_W-1:0]  fill_color;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic [ADDR_W-1:0] addr_in;
  logic [PIX_W-1:0]  data_in;
  logic              abort;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic [PIX_W-1:0]  data_out;
  logic              busy;
  logic              done;
  logic              error;
  logic [2:0]        state_dbg;

  always #5 clock = ~clock;

  scale_engine #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .PIX_W(PIX_W), .RD_LAT(RD_LAT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .operation(operation),
    .scale_shift(scale_shift), .clear_en(clear_en), .fill_color(fill_color),
    .src_base(src_base), .dst_base(dst_base), .addr_in(addr_in), .data_in(data_in),
    .abort(abort), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .data_out(data_out),
    .busy(busy), .done(done), .error(error), .state_dbg(state_dbg)
  );

  // RAM model: bench preload port has priority, read data two cycles late
  logic [7:0] mem [0:255];
  logic [7:0] rd_pipe1, rd_pipe2;
  logic       tb_we;
  logic [7:0] tb_waddr, tb_wdata;
  assign rd_data = rd_pipe2;

  always @(posedge clock) begin
    if (tb_we)      mem[tb_waddr] <= tb_wdata;
    else if (wr_en) mem[wr_addr]  <= wr_data;
    rd_pipe1 <= mem[rd_addr];
    rd_pipe2 <= rd_pipe1;
  end

  // Strobe counters
  int wr_cnt, rd_cnt, done_cnt, err_cnt, both_cnt;
  always @(posedge clock) begin
    if (wr_en)          wr_cnt   <= wr_cnt + 1;
    if (rd_en)          rd_cnt   <= rd_cnt + 1;
    if (done)           done_cnt <= done_cnt + 1;
    if (error)          err_cnt  <= err_cnt + 1;
    if (rd_en && wr_en) both_cnt <= both_cnt + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Present a command with start for one cycle; returns one cycle later
  task automatic issue(input logic [2:0] op, input logic [1:0] sc, input logic clr,
                       input logic [7:0] fill, input logic [7:0] src, input logic [7:0] dst,
                       input logic [7:0] adr, input logic [7:0] dat);
    operation   = op;
    scale_shift = sc;
    clear_en    = clr;
    fill_color  = fill;
    src_base    = src;
    dst_base    = dst;
    addr_in     = adr;
    data_in     = dat;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (state_dbg != 3'd0 && n < max_cyc) begin
      tick();
      n++;
    end
    chk(tag, {29'd0, state_dbg}, 32'd0);
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    tb_we    = 1'b1;
    tb_waddr = a;
    tb_wdata = d;
    tick();
    tb_we    = 1'b0;
  endtask

  int w0, r0, d0, e0, bad, sx, sy, idx;
  bit found;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; operation = '0; scale_shift = '0; clear_en = 1'b0;
    fill_color = '0; src_base = '0; dst_base = '0; addr_in = '0; data_in = '0;
    abort = 1'b0; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    repeat (3) tick();
    chk("rst_state", {29'd0, state_dbg}, 32'd0);
    chk("rst_ctrl", {28'd0, rd_en, wr_en, busy, done}, 32'd0);
    chk("rst_err_dout", {23'd0, error, data_out}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Source frame at 0: value y*8+x; destination frame at 64 cleared
    for (int a = 0; a < 32; a++) poke(8'(a), 8'(a));
    for (int a = 64; a < 96; a++) poke(8'(a), 8'h00);

    // WR 0xA5 to address 5
    issue(OP_WR, 2'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'd5, 8'hA5);
    chk("wr_strobe", {31'd0, wr_en}, 32'd1);
    chk("wr_addr", {24'd0, wr_addr}, 32'd5);
    chk("wr_data", {24'd0, wr_data}, 32'hA5);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("wr_done", {30'd0, done, wr_en}, 32'd2);
    chk("wr_busy_low", {31'd0, busy}, 32'd0);
    tick();
    chk("wr_mem", {24'd0, mem[5]}, 32'hA5);

    // RD address 5: done and data four cycles after start
    d0 = done_cnt;
    issue(OP_RD, 2'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'd5, 8'h00);
    chk("rd_strobe", {23'd0, rd_en, rd_addr}, {23'd0, 1'b1, 8'd5});
    tick();
    tick();
    chk("rd_not_done_early", {31'd0, done}, 32'd0);
    tick();
    chk("rd_done", {31'd0, done}, 32'd1);
    chk("rd_data_out", {24'd0, data_out}, 32'hA5);
    tick();
    chk("rd_done_once", done_cnt - d0, 32'd1);

    // ZOOM_IN x2 from 0 to 64
    w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
    issue(OP_ZIN, 2'd1, 1'b0, 8'h00, 8'd0, 8'd64, 8'd0, 8'd0);
    wait_idle(2000, "zin_finish");
    tick();
    chk("zin_writes", wr_cnt - w0, 32'd32);
    chk("zin_reads", rd_cnt - r0, 32'd16);
    chk("zin_done", done_cnt - d0, 32'd1);
    chk("zin_dst_3_1", {24'd0, mem[64 + 8 + 3]}, 32'd11);
    chk("zin_dst_0_0", {24'd0, mem[64]}, 32'd10);
    chk("zin_dst_7_3", {24'd0, mem[95]}, 32'd21);
    bad = 0;
    for (int y = 0; y < IMG_H; y++) begin
      for (int x = 0; x < IMG_W; x++) begin
        sx = (x >> 1) + 2;
        sy = (y >> 1) + 1;
        if (int'(mem[64 + y * 8 + x]) != sy * 8 + sx) bad++;
      end
    end
    chk("zin_frame_bad", bad, 32'd0);

    // ZOOM_OUT x4 with clear to 0xFF
    w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
    issue(OP_ZOUT, 2'd2, 1'b1, 8'hFF, 8'd0, 8'd64, 8'd0, 8'd0);
    wait_idle(2000, "zout_finish");
    tick();
    chk("zout_writes", wr_cnt - w0, 32'd34);
    chk("zout_reads", rd_cnt - r0, 32'd2);
    chk("zout_done", done_cnt - d0, 32'd1);
    chk("zout_dst_3_1", {24'd0, mem[64 + 8 + 3]}, 32'd0);
    chk("zout_dst_4_1", {24'd0, mem[64 + 8 + 4]}, 32'd4);
    bad = 0;
    for (int a = 64; a < 96; a++) begin
      if (a != 75 && a != 76 && mem[a] != 8'hFF) bad++;
    end
    chk("zout_fill_bad", bad, 32'd0);

    // Illegal commands
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    issue(3'b111, 2'd1, 1'b0, 8'h00, 8'd0, 8'd64, 8'd0, 8'd0);
    chk("ill_op_err", {30'd0, error, busy}, 32'd2);
    tick();
    chk("ill_op_err_pulse", {29'd0, state_dbg} + {31'd0, error}, 32'd0);
    issue(OP_ZIN, 2'd0, 1'b0, 8'h00, 8'd0, 8'd64, 8'd0, 8'd0);
    chk("ill_scale_err", {30'd0, error, busy}, 32'd2);
    tick();
    tick();
    chk("ill_err_count", err_cnt - e0, 32'd2);
    chk("ill_no_strobes", (wr_cnt - w0) + (rd_cnt - r0), 32'd0);

    // Abort on the 10th write of a zoom-in, then restart immediately
    w0 = wr_cnt; d0 = done_cnt;
    issue(OP_ZIN, 2'd1, 1'b0, 8'h00, 8'd0, 8'd64, 8'd0, 8'd0);
    found = 1'b0;
    idx = 0;
    while (!found && idx < 1000) begin
      if (wr_en && (wr_cnt - w0 == 9)) found = 1'b1;
      else begin
        tick();
        idx++;
      end
    end
    chk("abort_reached", {31'd0, found}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_state", {29'd0, state_dbg}, 32'd0);
    chk("abort_writes", wr_cnt - w0, 32'd10);
    chk("abort_no_done", done_cnt - d0, 32'd0);
    issue(OP_WR, 2'd0, 1'b0, 8'h00, 8'd0, 8'd0, 8'd100, 8'h3C);
    chk("abort_restart", {30'd0, busy, wr_en}, 32'd3);
    tick();
    tick();
    chk("abort_restart_mem", {24'd0, mem[100]}, 32'h3C);

    // Reset mid zoom-out clear
    issue(OP_ZOUT, 2'd2, 1'b1, 8'h11, 8'd0, 8'd64, 8'd0, 8'd0);
    repeat (5) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ctrl", {26'd0, rd_en, wr_en, busy, done, error, 1'b0}, 32'd0);
    chk("arst_bus", {8'd0, wr_addr, wr_data, data_out}, 32'd0);
    chk("arst_state", {29'd0, state_dbg}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    w0 = wr_cnt;
    repeat (3) tick();
    chk("arst_after_state", {29'd0, state_dbg}, 32'd0);
    chk("arst_after_quiet", wr_cnt - w0, 32'd0);
    chk("never_rd_and_wr", both_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
